uart_module_rx: RTL and testbench

- UART receiver: recovers 8N1 frames from the asynchronous `rx_uart` line. Frame format is start bit (0), 8 data bits LSB first, stop bit (1).
- Delivers each received byte with a one-cycle valid strobe and flags bad stop bits.
- Sits opposite the team's UART transmitter on the radio serial link and uses the same clock/baud parameterisation, so paired instances interoperate.

---
 rtl/uart_module_rx_if.sv | 32 +++
 rtl/uart_module_rx.sv | 150 +++++++++++++++
 tb/tb_uart_module_rx.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_module_rx_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : uart_module_rx_if
// Description : Serial line input and received-byte outputs of the UART receiver.
// Revision    : 1.0 - initial release
// ============================================================================
interface uart_module_rx_if;
    logic       rx_uart;
    logic [7:0] recv_byte;
    logic       recv_valid;
    logic       frame_err;
    logic       rx_busy;

    // master: the receiver itself; slave: the line driver / byte consumer
    modport master (
        input  rx_uart,
        output recv_byte,
        output recv_valid,
        output frame_err,
        output rx_busy
    );

    modport slave (
        output rx_uart,
        input  recv_byte,
        input  recv_valid,
        input  frame_err,
        input  rx_busy
    );
endinterface
`default_nettype wire

// File: rtl/uart_module_rx.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : uart_module_rx
// Description : 8N1 UART receiver, mid-bit sampling from a single falling edge.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_module_rx #(
    parameter int INPUT_CLK = 50000000,
    parameter int BAUD_RATE = 230400
) (
    input  wire logic          clk,
    input  wire logic          kill_n,
    uart_module_rx_if.master   bus
);

    localparam int BIT_PERIOD  = INPUT_CLK / BAUD_RATE;
    localparam int HALF_PERIOD = BIT_PERIOD / 2;
    localparam int CNT_W       = $clog2(BIT_PERIOD) + 1;

    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(BIT_PERIOD - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_PERIOD - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } state_t;

    logic             sync1_q;
    logic             rx_s_q;
    logic             rx_s_d_q;

    state_t           state_q,   state_d;
    logic [CNT_W-1:0] cnt_q,     cnt_d;
    logic [2:0]       bit_idx_q, bit_idx_d;
    logic [7:0]       shift_q,   shift_d;
    logic [7:0]       byte_q,    byte_d;
    logic             valid_q,   valid_d;
    logic             err_q,     err_d;

    // Synchroniser and edge-history flops preset high so reset never looks like a start edge
    always_ff @(posedge clk or negedge kill_n) begin
        if (!kill_n) begin
            sync1_q  <= 1'b1;
            rx_s_q   <= 1'b1;
            rx_s_d_q <= 1'b1;
        end else begin
            sync1_q  <= bus.rx_uart;
            rx_s_q   <= sync1_q;
            rx_s_d_q <= rx_s_q;
        end
    end

    always_ff @(posedge clk or negedge kill_n) begin
        if (!kill_n) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
            byte_q    <= '0;
            valid_q   <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            byte_q    <= byte_d;
            valid_q   <= valid_d;
            err_q     <= err_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        byte_d    = byte_q;
        valid_d   = 1'b0;
        err_d     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // Only a real high-to-low transition starts a frame; a held-low line does not
                if (rx_s_d_q && !rx_s_q) begin
                    state_d = ST_START;
                    cnt_d   = '0;
                end
            end

            ST_START: begin
                if (cnt_q == HALF_LAST) begin
                    cnt_d = '0;
                    if (!rx_s_q) begin
                        state_d   = ST_DATA;
                        bit_idx_d = '0;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            ST_DATA: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d     = '0;
                    shift_d   = {rx_s_q, shift_q[7:1]};
                    bit_idx_d = bit_idx_q + 3'd1;
                    if (bit_idx_q == 3'd7) begin
                        state_d = ST_STOP;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            ST_STOP: begin
                // Leaving at mid-stop-bit leaves half a bit to catch a back-to-back start edge
                if (cnt_q == BIT_LAST) begin
                    cnt_d   = '0;
                    state_d = ST_IDLE;
                    if (rx_s_q) begin
                        byte_d  = shift_q;
                        valid_d = 1'b1;
                    end else begin
                        err_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    assign bus.recv_byte  = byte_q;
    assign bus.recv_valid = valid_q;
    assign bus.frame_err  = err_q;
    assign bus.rx_busy    = (state_q != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_uart_module_rx.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_uart_module_rx
// Description : Self-checking bench for uart_module_rx (vector table + random frames).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_module_rx;

    localparam int BIT  = 50000000 / 230400;
    localparam int HALF = BIT / 2;

    logic clk    = 1'b0;
    logic kill_n = 1'b0;

    uart_module_rx_if bus ();

    uart_module_rx #(
        .INPUT_CLK (50000000),
        .BAUD_RATE (230400)
    ) dut (
        .clk    (clk),
        .kill_n (kill_n),
        .bus    (bus)
    );

    always #10 clk = ~clk;

    int checks  = 0;
    int errors  = 0;
    int n_valid = 0;
    int n_err   = 0;

    typedef struct {
        logic [7:0] data;
        logic       stop;
        int         per;
        int         gap_bits;
        int         exp_v;
        int         exp_e;
        logic [7:0] exp_byte;
    } vec_t;

    vec_t vecs [13];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Strobe monitor: counts pulses and checks mutual exclusion
    always @(negedge clk) begin
        if (kill_n) begin
            if (bus.recv_valid) n_valid++;
            if (bus.frame_err)  n_err++;
            if (bus.recv_valid || bus.frame_err) begin
                checks++;
                if (bus.recv_valid && bus.frame_err) begin
                    errors++;
                    $display("FAIL strobe_excl: valid=%0b err=%0b both high", bus.recv_valid, bus.frame_err);
                end
            end
        end
    end

    task automatic idle(input int cycles);
        bus.rx_uart = 1'b1;
        repeat (cycles) @(negedge clk);
    endtask

    // Sends one 8N1 frame; optional short inverted glitch early in each data bit
    task automatic send_frame(input logic [7:0] d, input logic stop, input int per, input bit glitch);
        bus.rx_uart = 1'b0;
        repeat (per) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            bus.rx_uart = d[i];
            if (glitch) begin
                repeat (5) @(negedge clk);
                bus.rx_uart = ~d[i];
                repeat (10) @(negedge clk);
                bus.rx_uart = d[i];
                repeat (per - 15) @(negedge clk);
            end else begin
                repeat (per) @(negedge clk);
            end
        end
        bus.rx_uart = stop;
        repeat (per) @(negedge clk);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_byte"},  {24'd0, bus.recv_byte}, 32'h00);
        check({tag, "_valid"}, {31'd0, bus.recv_valid}, 32'd0);
        check({tag, "_err"},   {31'd0, bus.frame_err}, 32'd0);
        check({tag, "_busy"},  {31'd0, bus.rx_busy}, 32'd0);
    endtask

    initial begin
        int         v0, e0, busy_cnt, lat;
        bit         found;
        logic [7:0] model_byte;
        logic [7:0] d;
        logic       stop;
        int         per, gap;
        bit         gl;
        logic [7:0] rd;

        bus.rx_uart = 1'b1;

        vecs[0]  = '{8'h55, 1'b1, 217, 5, 1, 0, 8'h55};
        vecs[1]  = '{8'hA5, 1'b1, 217, 5, 1, 0, 8'hA5};
        vecs[2]  = '{8'h00, 1'b1, 217, 0, 1, 0, 8'h00};
        vecs[3]  = '{8'hFF, 1'b1, 217, 0, 1, 0, 8'hFF};
        vecs[4]  = '{8'h81, 1'b1, 217, 0, 1, 0, 8'h81};
        vecs[5]  = '{8'h00, 1'b1, 211, 0, 1, 0, 8'h00};
        vecs[6]  = '{8'hFF, 1'b1, 211, 0, 1, 0, 8'hFF};
        vecs[7]  = '{8'h81, 1'b1, 211, 0, 1, 0, 8'h81};
        vecs[8]  = '{8'h00, 1'b1, 223, 0, 1, 0, 8'h00};
        vecs[9]  = '{8'hFF, 1'b1, 223, 0, 1, 0, 8'hFF};
        vecs[10] = '{8'h81, 1'b1, 223, 2, 1, 0, 8'h81};
        vecs[11] = '{8'h5A, 1'b0, 217, 2, 0, 1, 8'h81};
        vecs[12] = '{8'h12, 1'b1, 217, 1, 1, 0, 8'h12};

        // Reset state, held and just after release
        repeat (5) @(negedge clk);
        check_reset_outputs("rst_held");
        kill_n = 1'b1;
        @(negedge clk);
        check_reset_outputs("rst_rel");
        idle(50);

        // Vector table
        for (int k = 0; k < 13; k++) begin
            v0 = n_valid;
            e0 = n_err;
            send_frame(vecs[k].data, vecs[k].stop, vecs[k].per, 1'b0);
            check($sformatf("vec%0d_valid", k), n_valid - v0, vecs[k].exp_v);
            check($sformatf("vec%0d_err", k),   n_err - e0,   vecs[k].exp_e);
            check($sformatf("vec%0d_byte", k),  {24'd0, bus.recv_byte}, {24'd0, vecs[k].exp_byte});
            idle(vecs[k].gap_bits * vecs[k].per);
        end
        model_byte = 8'h12;

        // 50-cycle glitch on idle line
        v0 = n_valid;
        e0 = n_err;
        busy_cnt = 0;
        bus.rx_uart = 1'b0;
        for (int i = 0; i < 350; i++) begin
            if (i == 50) bus.rx_uart = 1'b1;
            @(negedge clk);
            if (bus.rx_busy) busy_cnt++;
        end
        check("glitch_busy_len", {31'd0, (busy_cnt >= HALF - 2) && (busy_cnt <= HALF + 2)}, 32'd1);
        check("glitch_no_valid", n_valid - v0, 32'd0);
        check("glitch_no_err",   n_err - e0,   32'd0);
        check("glitch_busy_end", {31'd0, bus.rx_busy}, 32'd0);

        // Bad stop bit followed by a 20-bit break
        v0 = n_valid;
        e0 = n_err;
        send_frame(8'h3C, 1'b0, BIT, 1'b0);
        repeat (20 * BIT) @(negedge clk);
        check("brk_err",      n_err - e0,   32'd1);
        check("brk_valid",    n_valid - v0, 32'd0);
        check("brk_byte",     {24'd0, bus.recv_byte}, {24'd0, model_byte});
        check("brk_busy_low", {31'd0, bus.rx_busy}, 32'd0);
        idle(2 * BIT);
        check("brk_rel_err",   n_err - e0,   32'd1);
        check("brk_rel_valid", n_valid - v0, 32'd0);

        // Random frames against the reference model
        for (int k = 0; k < 8; k++) begin
            d    = 8'($urandom);
            stop = ($urandom_range(0, 5) != 0);
            per  = $urandom_range(211, 223);
            gl   = 1'($urandom_range(0, 1));
            gap  = $urandom_range(stop ? 0 : 1, 3);
            if (stop) model_byte = d;
            v0 = n_valid;
            e0 = n_err;
            send_frame(d, stop, per, gl);
            check($sformatf("rnd%0d_valid", k), n_valid - v0, {31'd0, stop});
            check($sformatf("rnd%0d_err", k),   n_err - e0,   {31'd0, ~stop});
            check($sformatf("rnd%0d_byte", k),  {24'd0, bus.recv_byte}, {24'd0, model_byte});
            idle(gap * per);
        end
        idle(BIT);

        // Strobe latency and width on 0x01, measured from the pin
        found = 1'b0;
        lat   = 0;
        fork
            send_frame(8'h01, 1'b1, BIT, 1'b0);
            begin
                for (int i = 1; i < 3000 && !found; i++) begin
                    @(negedge clk);
                    if (bus.recv_valid) begin
                        lat   = i;
                        found = 1'b1;
                    end
                end
                if (found) begin
                    @(negedge clk);
                    check("lat_width",   {31'd0, bus.recv_valid}, 32'd0);
                    check("lat_busy_lo", {31'd0, bus.rx_busy}, 32'd0);
                end
            end
        join
        check("lat_found",  {31'd0, found}, 32'd1);
        check("lat_window", {31'd0, (lat >= HALF + 9 * BIT + 1) && (lat <= HALF + 9 * BIT + 3)}, 32'd1);
        check("lat_byte",   {24'd0, bus.recv_byte}, 32'h01);
        idle(BIT);

        // Reset pulse during bit 4 of a frame
        v0 = n_valid;
        e0 = n_err;
        rd = 8'hA6;
        bus.rx_uart = 1'b0;
        repeat (BIT) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            bus.rx_uart = rd[i];
            repeat (BIT) @(negedge clk);
        end
        bus.rx_uart = rd[4];
        repeat (100) @(negedge clk);
        #3;
        kill_n = 1'b0;
        bus.rx_uart = 1'b1;
        #1;
        check_reset_outputs("kill_async");
        repeat (3) @(negedge clk);
        kill_n = 1'b1;
        idle(12 * BIT);
        check("kill_no_valid", n_valid - v0, 32'd0);
        check("kill_no_err",   n_err - e0,   32'd0);
        send_frame(8'hC3, 1'b1, BIT, 1'b0);
        check("post_kill_valid", n_valid - v0, 32'd1);
        check("post_kill_byte",  {24'd0, bus.recv_byte}, 32'hC3);
        idle(BIT);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
